// File: rtl/debug_run_ctrl.sv
// -----------------------------------------------------------------------------
// debug_run_ctrl
//
// UART-driven debug controller for the MIPS pipeline. Single-byte commands
// arrive from the UART rx FIFO, some followed by argument bytes. The block
// gates pipeline clock edges through pipe_clk_en, so it can single-step,
// step N, run to the end of the program, or run to a breakpoint. It can also
// issue a software reset to the pipeline. Every command finishes by asking
// the debug tx framer for a state dump.
//
// Commands
//   0x31  step one edge
//   0x32  run until finished / breakpoint / watchdog timeout
//   0x33  software reset of the pipeline (the breakpoint is kept)
//   0x34  step N edges, N = next byte (N = 0 gives no edges)
//   0x35  set breakpoint, PC_W/8 bytes follow, least significant byte first
//   0x36  clear breakpoint
//   other unknown, only a dump is requested
//
// Parameters
//   PC_W        width of pc and of the breakpoint register (multiple of 8)
//   TIMEOUT_W   run watchdog width; a run stops after 2**TIMEOUT_W-1 edges
//   RST_CYCLES  cycles pipeline_reset is held on a software reset (>= 1)
//
// Ports
//   clock                   system clock
//   reset                   asynchronous, active-low reset
//   r_data                  head byte of the UART rx FIFO
//   rx_ready                rx FIFO not empty
//   rd_uart                 one-cycle pop strobe for the rx FIFO
//   pc                      current pipeline PC
//   program_finished        sticky halt flag from the pipeline
//   clear_program_finished  clears program_finished
//   pipe_clk_en             pipeline takes an edge on each clock with this high
//   pipeline_reset          synchronous reset to the pipeline
//   send_signal             dump request, held until data_sent
//   data_sent               dump complete (level or pulse)
//   stop_cause              0 step done, 1 finished, 2 breakpoint, 3 timeout
//   current_state           FSM state, for the debug LEDs
// -----------------------------------------------------------------------------
module debug_run_ctrl #(
  parameter int PC_W       = 32,
  parameter int TIMEOUT_W  = 24,
  parameter int RST_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      r_data,
  input  logic            rx_ready,
  output logic            rd_uart,
  input  logic [PC_W-1:0] pc,
  input  logic            program_finished,
  output logic            clear_program_finished,
  output logic            pipe_clk_en,
  output logic            pipeline_reset,
  output logic            send_signal,
  input  logic            data_sent,
  output logic [1:0]      stop_cause,
  output logic [2:0]      current_state
);

  // ---------------------------------------------------------------------------
  // Constants and types
  // ---------------------------------------------------------------------------
  localparam logic [7:0] CMD_STEP1  = 8'h31;
  localparam logic [7:0] CMD_RUN    = 8'h32;
  localparam logic [7:0] CMD_SWRST  = 8'h33;
  localparam logic [7:0] CMD_STEPN  = 8'h34;
  localparam logic [7:0] CMD_SET_BP = 8'h35;
  localparam logic [7:0] CMD_CLR_BP = 8'h36;

  localparam int BP_BYTES = PC_W / 8;
  localparam int ARG_W    = $clog2(BP_BYTES + 1);
  localparam int RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_WAITING  = 3'd1,
    S_ARG      = 3'd2,
    S_RUN      = 3'd3,
    S_SW_RESET = 3'd4,
    S_UNKNOWN  = 3'd5,
    S_SENDING  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_STEP     = 2'd0,
    CAUSE_FINISHED = 2'd1,
    CAUSE_BP       = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state;
  logic                 arg_is_bp;   // ARG collects breakpoint bytes (else N)
  logic [ARG_W-1:0]     arg_left;    // breakpoint bytes still to come
  logic [7:0]           cnt;         // edges still allowed in a limited run
  logic                 limited;     // run is bounded by cnt
  logic                 first;       // first RUN cycle: breakpoint masked
  logic [TIMEOUT_W-1:0] tmo;         // edges taken in the current run
  logic [PC_W-1:0]      bp;
  logic                 bp_valid;
  logic [RST_W-1:0]     rst_left;    // SW_RESET cycles remaining after this one

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic   byte_accept;
  logic   stop_fin, stop_bp, stop_cnt, stop_tmo, run_stop;
  logic   in_reset_state;
  cause_t stop_code;

  // A byte is taken only when the previous pop has completed, so a FIFO that
  // still shows the popped byte for one cycle is never read twice.
  assign byte_accept = ((state == S_WAITING) || (state == S_ARG)) &&
                       rx_ready && !rd_uart;

  // Resuming from a breakpoint: the first RUN cycle ignores pc == bp so the
  // pipeline can step off the instruction it stopped on.
  assign stop_fin = program_finished;
  assign stop_bp  = bp_valid && (pc == bp) && !first;
  assign stop_cnt = limited && (cnt == 8'd0);
  assign stop_tmo = &tmo;
  assign run_stop = stop_fin || stop_bp || stop_cnt || stop_tmo;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    stop_code = CAUSE_TIMEOUT;
    if (stop_fin)      stop_code = CAUSE_FINISHED;
    else if (stop_bp)  stop_code = CAUSE_BP;
    else if (stop_cnt) stop_code = CAUSE_STEP;
  end

  // Pipeline reset/clear are pure decodes of the state register, so they
  // change only on clock edges and stay glitch-free.
  assign in_reset_state         = (state == S_INIT) || (state == S_SW_RESET);
  assign pipeline_reset         = in_reset_state;
  assign clear_program_finished = in_reset_state;

  // While running, the edge is gated in the same cycle a stop condition shows
  // up; this is what makes step N produce exactly N edges.
  assign pipe_clk_en = (state == S_RUN) ? !run_stop : in_reset_state;

  assign current_state = state;

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the values from before the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_INIT;
      arg_is_bp   <= 1'b0;
      arg_left    <= '0;
      cnt         <= '0;
      limited     <= 1'b0;
      first       <= 1'b0;
      tmo         <= '0;
      bp          <= '0;
      bp_valid    <= 1'b0;
      rst_left    <= '0;
      rd_uart     <= 1'b0;
      send_signal <= 1'b0;
      stop_cause  <= CAUSE_STEP;
    end else begin
      // Pop strobe is high exactly in the cycle after a byte was taken.
      rd_uart <= byte_accept;

      case (state)
        S_INIT: begin
          state <= S_WAITING;
        end

        S_WAITING: begin
          if (byte_accept) begin
            case (r_data)
              CMD_STEP1: begin
                cnt     <= 8'd1;
                limited <= 1'b1;
                first   <= 1'b1;
                tmo     <= '0;
                state   <= S_RUN;
              end
              CMD_RUN: begin
                limited <= 1'b0;
                first   <= 1'b1;
                tmo     <= '0;
                state   <= S_RUN;
              end
              CMD_SWRST: begin
                rst_left <= RST_W'(RST_CYCLES - 1);
                state    <= S_SW_RESET;
              end
              CMD_STEPN: begin
                arg_is_bp <= 1'b0;
                arg_left  <= ARG_W'(1);
                state     <= S_ARG;
              end
              CMD_SET_BP: begin
                arg_is_bp <= 1'b1;
                arg_left  <= ARG_W'(BP_BYTES);
                state     <= S_ARG;
              end
              CMD_CLR_BP: begin
                bp_valid    <= 1'b0;
                send_signal <= 1'b1;
                state       <= S_SENDING;
              end
              default: begin
                state <= S_UNKNOWN;
              end
            endcase
          end
        end

        S_ARG: begin
          if (byte_accept) begin
            if (!arg_is_bp) begin
              cnt <= r_data;
              if (r_data == 8'd0) begin
                // Step 0: report as a finished step without touching the pipe.
                stop_cause  <= CAUSE_STEP;
                send_signal <= 1'b1;
                state       <= S_SENDING;
              end else begin
                limited <= 1'b1;
                first   <= 1'b1;
                tmo     <= '0;
                state   <= S_RUN;
              end
            end else begin
              // Little-endian: each new byte enters at the top and earlier
              // bytes move down, so the first byte ends up in bits [7:0].
              bp       <= (bp >> 8) | (PC_W'(r_data) << (PC_W - 8));
              arg_left <= arg_left - ARG_W'(1);
              if (arg_left == ARG_W'(1)) begin
                bp_valid    <= 1'b1;
                send_signal <= 1'b1;
                state       <= S_SENDING;
              end
            end
          end
        end

        S_RUN: begin
          first <= 1'b0;
          if (run_stop) begin
            stop_cause  <= stop_code;
            send_signal <= 1'b1;
            state       <= S_SENDING;
          end else begin
            // This cycle gave the pipeline an edge.
            if (limited) cnt <= cnt - 8'd1;
            tmo <= tmo + TIMEOUT_W'(1);
          end
        end

        S_SW_RESET: begin
          if (rst_left == '0) begin
            stop_cause  <= CAUSE_STEP;
            send_signal <= 1'b1;
            state       <= S_SENDING;
          end else begin
            rst_left <= rst_left - RST_W'(1);
          end
        end

        S_UNKNOWN: begin
          send_signal <= 1'b1;
          state       <= S_SENDING;
        end

        S_SENDING: begin
          if (data_sent) begin
            send_signal <= 1'b0;
            state       <= S_WAITING;
          end
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debug_run_ctrl
//
// Drives debug_run_ctrl with command byte streams through a modelled rx FIFO,
// models the pipeline (pc advances by 4 per enabled edge, a sticky finished
// flag raised after a chosen number of edges) and the dump framer (data_sent
// after a random delay). Expected edge counts, stop causes, pops and pc come
// from a command-level reference model.
// -----------------------------------------------------------------------------
module tb_debug_run_ctrl;

  localparam int PC_W      = 32;
  localparam int TW        = 6;
  localparam int RSTC      = 2;
  localparam int TMO_EDGES = (1 << TW) - 1;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      r_data;
  logic            rx_ready;
  logic            rd_uart;
  logic [PC_W-1:0] pc = '0;
  logic            program_finished = 1'b0;
  logic            clear_program_finished;
  logic            pipe_clk_en;
  logic            pipeline_reset;
  logic            send_signal;
  logic            data_sent = 1'b0;
  logic [1:0]      stop_cause;
  logic [2:0]      current_state;

  debug_run_ctrl #(
    .PC_W      (PC_W),
    .TIMEOUT_W (TW),
    .RST_CYCLES(RSTC)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .r_data                (r_data),
    .rx_ready              (rx_ready),
    .rd_uart               (rd_uart),
    .pc                    (pc),
    .program_finished      (program_finished),
    .clear_program_finished(clear_program_finished),
    .pipe_clk_en           (pipe_clk_en),
    .pipeline_reset        (pipeline_reset),
    .send_signal           (send_signal),
    .data_sent             (data_sent),
    .stop_cause            (stop_cause),
    .current_state         (current_state)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // rx FIFO model
  // ---------------------------------------------------------------------------
  logic [7:0] rx_buf [1024];
  int         rx_head = 0;
  int         rx_tail = 0;

  assign rx_ready = (rx_head != rx_tail);
  assign r_data   = rx_buf[rx_head[9:0]];

  // ---------------------------------------------------------------------------
  // Pipeline / framer model and event counters
  // ---------------------------------------------------------------------------
  int   edges      = 0;
  int   rd_count   = 0;
  int   rst_count  = 0;
  int   sends_done = 0;
  int   dbl_pops   = 0;
  int   bad_idle   = 0;
  logic rd_prev    = 1'b0;
  bit   fin_arm    = 1'b0;
  int   fin_at     = 0;

  always @(posedge clock) begin
    if (rd_uart) rx_head <= rx_head + 1;

    if (pipeline_reset)   pc <= '0;
    else if (pipe_clk_en) pc <= pc + 32'd4;

    if (clear_program_finished)
      program_finished <= 1'b0;
    else if (fin_arm && pipe_clk_en && !pipeline_reset && (edges + 1 == fin_at))
      program_finished <= 1'b1;

    if (pipe_clk_en && !pipeline_reset) edges <= edges + 1;
    if (rd_uart) rd_count <= rd_count + 1;
    if (rd_uart && rd_prev) dbl_pops <= dbl_pops + 1;
    rd_prev <= rd_uart;
    if (pipeline_reset && clear_program_finished && pipe_clk_en) rst_count <= rst_count + 1;
    if (send_signal && data_sent) sends_done <= sends_done + 1;
    if ((current_state == 3'd6 && (!send_signal || pipe_clk_en)) ||
        (current_state == 3'd1 && (pipe_clk_en || pipeline_reset || send_signal)))
      bad_idle <= bad_idle + 1;

    data_sent <= send_signal && !data_sent && ($urandom_range(0, 2) == 0);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: command-level behaviour
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc       = '0;
  logic [31:0] m_bp       = '0;
  bit          m_bp_valid = 1'b0;
  int          m_cause    = 0;
  bit          m_fin      = 1'b0;

  // A run stops at the earliest of several edge counts; on a tie the higher
  // priority cause wins (finished > breakpoint > step limit > timeout).
  function automatic void model_run(input int limit, input int fin_rel,
                                    output int e, output int c);
    logic [31:0] d;
    if (m_fin) begin
      e = 0;
      c = 1;
    end else begin
      e = TMO_EDGES;
      c = 3;
      if (limit >= 0 && limit <= e) begin
        e = limit;
        c = 0;
      end
      d = m_bp - m_pc;
      if (m_bp_valid && m_bp > m_pc && d[1:0] == 2'b00 && d[31:2] <= 30'(e)) begin
        e = int'(d[31:2]);
        c = 2;
      end
      if (fin_rel > 0 && fin_rel <= e) begin
        e = fin_rel;
        c = 1;
      end
    end
    m_pc    = m_pc + 32'(4 * e);
    m_fin   = (c == 1);
    m_cause = c;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push(input logic [7:0] b);
    rx_buf[rx_tail[9:0]] = b;
    rx_tail = rx_tail + 1;
  endtask

  task automatic wait_done(input int base_sends, input int n);
    int i;
    i = 0;
    while (i < 3000 && !(sends_done >= base_sends + n && current_state == 3'd1 && !rx_ready)) begin
      @(negedge clock);
      i++;
    end
    check("cmd_complete", (i < 3000), 1);
  endtask

  task automatic exec(input string tag, input int nbytes,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4,
                      input int fin_rel, input int exp_edges, input int exp_cause,
                      input int exp_rst);
    int e0, r0, s0, q0;
    e0 = edges; r0 = rd_count; s0 = sends_done; q0 = rst_count;
    if (fin_rel > 0) begin
      fin_at  = edges + fin_rel;
      fin_arm = 1'b1;
    end
    if (nbytes > 0) push(b0);
    if (nbytes > 1) push(b1);
    if (nbytes > 2) push(b2);
    if (nbytes > 3) push(b3);
    if (nbytes > 4) push(b4);
    wait_done(s0, 1);
    fin_arm = 1'b0;
    check({tag, "_edges"}, edges - e0, exp_edges);
    check({tag, "_pops"}, rd_count - r0, nbytes);
    check({tag, "_cause"}, stop_cause, exp_cause);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_rst_cycles"}, rst_count - q0, exp_rst);
  endtask

  task automatic do_step1(input int fin);
    int e, c;
    model_run(1, fin, e, c);
    exec("step1", 1, 8'h31, 8'h0, 8'h0, 8'h0, 8'h0, fin, e, c, 0);
  endtask

  task automatic do_stepn(input int n, input int fin);
    int e, c;
    logic [7:0] nb;
    nb = 8'(n);
    if (n == 0) begin
      e = 0; c = 0; m_cause = 0;
    end else begin
      model_run(n, fin, e, c);
    end
    exec("stepn", 2, 8'h34, nb, 8'h0, 8'h0, 8'h0, (n == 0) ? 0 : fin, e, c, 0);
  endtask

  task automatic do_run(input int fin);
    int e, c;
    model_run(-1, fin, e, c);
    exec("run", 1, 8'h32, 8'h0, 8'h0, 8'h0, 8'h0, fin, e, c, 0);
  endtask

  task automatic do_swrst();
    m_pc = '0; m_fin = 1'b0; m_cause = 0;
    exec("swrst", 1, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0, 0, 0, 0, RSTC);
  endtask

  task automatic do_setbp(input logic [31:0] v);
    m_bp = v; m_bp_valid = 1'b1;
    exec("setbp", 5, 8'h35, v[7:0], v[15:8], v[23:16], v[31:24], 0, 0, m_cause, 0);
  endtask

  task automatic do_clrbp();
    m_bp_valid = 1'b0;
    exec("clrbp", 1, 8'h36, 8'h0, 8'h0, 8'h0, 8'h0, 0, 0, m_cause, 0);
  endtask

  task automatic do_unknown(input logic [7:0] b);
    exec("unknown", 1, b, 8'h0, 8'h0, 8'h0, 8'h0, 0, 0, m_cause, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k, fin, e1, c1, e2, c2, s0, r0, ed0, i;

    // Reset state
    #2;
    check("rst_state", current_state, 3'd0);
    check("rst_rd_uart", rd_uart, 1'b0);
    check("rst_send", send_signal, 1'b0);
    check("rst_cause", stop_cause, 2'd0);
    check("rst_pipe_reset", pipeline_reset, 1'b1);
    check("rst_clear_fin", clear_program_finished, 1'b1);
    check("rst_clk_en", pipe_clk_en, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_state", current_state, 3'd1);
    check("post_rst_clk_en", pipe_clk_en, 1'b0);
    check("post_rst_pipe_reset", pipeline_reset, 1'b0);

    // Directed cases
    do_step1(0);
    do_stepn(5, 0);
    do_stepn(0, 0);
    do_swrst();
    do_setbp(32'h10);
    do_run(0);
    check("bp_stop_pc", pc, 32'h10);
    do_run(0);                      // resumes past the breakpoint
    do_swrst();
    do_run(0);                      // breakpoint survives a software reset
    do_swrst();
    do_clrbp();
    do_run(7);
    do_run(0);                      // already finished: no edges
    do_unknown(8'h41);              // cause stays 1
    do_swrst();

    // Randomized command mix
    for (int it = 0; it < 24; it++) begin
      k   = $urandom_range(0, 6);
      fin = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
      case (k)
        0: do_step1(fin);
        1: do_stepn($urandom_range(0, 20), fin);
        2: do_run(fin);
        3: do_swrst();
        4: do_setbp(m_pc + 32'($urandom_range(0, 30)) * 32'd4);
        5: do_clrbp();
        default: do_unknown(8'h37 + 8'($urandom_range(0, 64)));
      endcase
    end

    // Back-to-back bytes: step 3 then step 1 queued together
    do_swrst();
    do_clrbp();
    model_run(3, 0, e1, c1);
    model_run(1, 0, e2, c2);
    s0 = sends_done; r0 = rd_count; ed0 = edges;
    push(8'h34); push(8'h03); push(8'h31);
    wait_done(s0, 2);
    check("b2b_edges", edges - ed0, e1 + e2);
    check("b2b_pops", rd_count - r0, 3);
    check("b2b_cause", stop_cause, c2);
    check("b2b_pc", pc, m_pc);

    // Async reset in the middle of a run
    do_swrst();
    do_setbp(32'h20);
    push(8'h32);
    i = 0;
    while (i < 100 && current_state != 3'd3) begin
      @(negedge clock);
      i++;
    end
    check("midrun_entered", current_state, 3'd3);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_state", current_state, 3'd0);
    check("abort_rd_uart", rd_uart, 1'b0);
    check("abort_send", send_signal, 1'b0);
    check("abort_cause", stop_cause, 2'd0);
    check("abort_clk_en", pipe_clk_en, 1'b1);
    check("abort_pipe_reset", pipeline_reset, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_recover_state", current_state, 3'd1);
    check("abort_pc", pc, 32'h0);
    m_pc = '0; m_fin = 1'b0; m_cause = 0; m_bp_valid = 1'b0;
    do_run(0);                      // breakpoint was dropped: runs to timeout

    check("no_double_pop", dbl_pops, 0);
    check("idle_send_outputs", bad_idle, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
